sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock synchronous FIFO. It is the general-purpose buffering primitive for datapath blocks that sit between producer and consumer stages on one clock domain.
- Adds simultaneous read/write, exact full/empty at any depth, and programmable almost-full/almost-empty thresholds.
- Adds a wide occupancy count with a correct full-depth value.
- Optionally adds sticky overflow/underflow error reporting.

Parameters:
DATA_WIDTH, 32, width of each stored word in bits
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words (default 16)
AFULL_THRESH, 12, almost_full asserts when count >= AFULL_THRESH (range 1..DEPTH)
AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH (range 0..DEPTH-1)

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset; has priority over all other inputs
wr_en  input  1  write request
data_in  input  DATA_WIDTH  write data, sampled on the edge where the write is accepted
rd_en  input  1  read request
data_out  output  DATA_WIDTH  registered read data
empty  output  1  FIFO holds 0 words
full  output  1  FIFO holds DEPTH words
almost_empty  output  1  count <= AEMPTY_THRESH
almost_full  output  1  count >= AFULL_THRESH
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full (see Optional Feature)
underflow  output  1  sticky: read attempted while empty (see Optional Feature)

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array. Contents are not cleared by reset.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH bits wide. Each increments by 1 per accepted operation and wraps DEPTH-1 -> 0 naturally.
- Acceptance, evaluated from current registered flags:
  - wr_acc = wr_en & ~full
  - rd_acc = rd_en & ~empty
  - Requests not accepted are silently dropped; no state changes for them.
- Write: on wr_acc, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read: on rd_acc, data_out <= mem[rd_ptr] and rd_ptr increments.
  - data_out is valid from the clock edge where rd_en is accepted; latency is 1 cycle.
  - data_out holds its value when no read is accepted.
- Count update:
  - wr_acc only: +1
  - rd_acc only: -1
  - both accepted: unchanged
  - neither: unchanged
  - count never exceeds DEPTH and never goes below 0.
- Simultaneous read and write:
  - When 0 < count < DEPTH, both are accepted in the same cycle.
  - When full, only the read is accepted; the write is dropped and count becomes DEPTH-1.
  - When empty, only the write is accepted; the read is dropped and count becomes 1.
  - There is no write-through to data_out when empty.
- Flags are registered and computed from the next count, so they are exact in the cycle after the edge:
  - empty = (count_next == 0)
  - full = (count_next == DEPTH)
  - almost_empty = (count_next <= AEMPTY_THRESH)
  - almost_full = (count_next >= AFULL_THRESH)
- Reset values: wr_ptr=0, rd_ptr=0, count=0, data_out=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Reset asserted mid-operation discards all contents and in-flight requests on that edge. Requests on that edge are ignored.
- Implementation uses no initial blocks; reset alone defines state.

Optional Feature:
Macro: SYNC_FIFO_ERR_EN
- Defined:
  - overflow sets on any edge with wr_en & full & ~reset.
  - underflow sets on any edge with rd_en & empty & ~reset.
  - Both are sticky and are cleared only by reset.
- Not defined: overflow and underflow are tied to 0 and no error logic is synthesised.
- Ports are present in both builds.

Test Plan:
1. Fill: reset, then 16 writes of data_in=0x0..0xF -> count steps 1..16. almost_full first reads 1 after write 12 (count=12). full=1 after write 16. empty=0 after write 1.
2. Overflow drop: with full, write 0xDEAD -> count stays 16, memory unchanged. With SYNC_FIFO_ERR_EN, overflow=1 until reset.
3. Drain and order: 16 reads -> data_out returns 0x0..0xF in order, each one cycle after its rd_en edge. almost_empty=1 at count=2. empty=1 after read 16. A 17th read leaves data_out=0xF; underflow=1 if enabled.
4. Simultaneous R/W: preload 5 words, then 8 cycles of wr_en=rd_en=1 with new data -> count stays 5 and reads return preload then new data in order. At full with rd_en+wr_en -> count becomes 15 and the write is dropped.
5. Wrap-around: 3 rounds of 10 writes followed by 10 reads -> pointers wrap past 15, all 30 words read back correctly, and count ends at 0.
6. Reset mid-operation: with 7 words stored, assert reset for 1 cycle while wr_en=rd_en=1 -> next cycle count=0, empty=1, data_out=0, errors=0. A following write then read returns the new word.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered flags, occupancy count and programmable thresholds.
// Optional sticky overflow/underflow reporting is enabled by defining SYNC_FIFO_ERR_EN.
module sync_fifo_param #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 4,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
   localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count_next;
   logic                  wr_acc;
   logic                  rd_acc;

   // Handshake: a write (read) request is accepted on the rising edge where wr_en (rd_en) is
   // high and the registered full (empty) flag is low; refused requests are dropped silently.
   always_comb begin
      wr_acc     = wr_en & ~full;
      rd_acc     = rd_en & ~empty;
      count_next = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_next = count + ONE_C;
         2'b01:   count_next = count - ONE_C;
         default: count_next = count;
      endcase
   end

   // Storage is deliberately not reset; a write coinciding with reset is still ignored.
   always_ff @(posedge clk) begin
      if (!reset && wr_acc) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         data_out     <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_acc) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + PTR_ONE;
         end
         count        <= count_next;
         empty        <= (count_next == '0);
         full         <= (count_next == DEPTH_C);
         almost_empty <= (count_next <= AEMPTY_C);
         almost_full  <= (count_next >= AFULL_C);
      end
   end

`ifdef SYNC_FIFO_ERR_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a vector table for fill/overflow/drain/underflow,
// then hand-written sequences for simultaneous access, wrap-around and mid-operation reset.
module tb_sync_fifo_param;

   localparam int DW = 32;
   localparam int AW = 4;
`ifdef SYNC_FIFO_ERR_EN
   localparam logic ERR = 1'b1;
`else
   localparam logic ERR = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          wr_en;
   logic [DW-1:0] data_in;
   logic          rd_en;
   logic [DW-1:0] data_out;
   logic          empty;
   logic          full;
   logic          almost_empty;
   logic          almost_full;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   int checks = 0;
   int passes = 0;
   logic [DW-1:0] exp_q[$];

   sync_fifo_param #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(12), .AEMPTY_THRESH(2)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(data_out), .empty(empty), .full(full), .almost_empty(almost_empty),
      .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          wr;
      logic          rd;
      logic [DW-1:0] din;
      logic [AW:0]   cnt;
      logic          emp;
      logic          ful;
      logic          ae;
      logic          af;
      logic [DW-1:0] dout;
      logic          ovf;
      logic          unf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic wr, logic rd, logic [DW-1:0] din, int cnt, logic emp,
                               logic ful, logic ae, logic af, logic [DW-1:0] dout,
                               logic ovf, logic unf);
      vec_t v;
      v.wr = wr; v.rd = rd; v.din = din; v.cnt = (AW+1)'(cnt);
      v.emp = emp; v.ful = ful; v.ae = ae; v.af = af; v.dout = dout;
      v.ovf = ovf; v.unf = unf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         passes++;
      end
   endtask

   // Driver: present inputs, let one edge pass, then sample 1 time unit later.
   task automatic step(input logic wr, input logic rd, input logic [DW-1:0] din);
      wr_en   = wr;
      rd_en   = rd;
      data_in = din;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic push(input logic [DW-1:0] d);
      step(1'b1, 1'b0, d);
      exp_q.push_back(d);
   endtask

   task automatic pop_chk(input string name);
      logic [DW-1:0] e;
      step(1'b0, 1'b1, '0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk(name, data_out, e);
   endtask

   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      data_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_count", count, 0);
      chk("reset_empty", empty, 1);
      chk("reset_full", full, 0);
      chk("reset_aempty", almost_empty, 1);
      chk("reset_afull", almost_full, 0);
      chk("reset_dout", data_out, 0);
      chk("reset_ovf", overflow, 0);
      chk("reset_unf", underflow, 0);
      reset = 1'b0;

      // Fill 0x0..0xF, one dropped write when full, drain in order, one read past empty.
      for (int i = 0; i < 16; i++)
         vecs.push_back(mk(1, 0, i, i + 1, 0, i == 15, (i + 1) <= 2, (i + 1) >= 12, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'hDEAD, 16, 0, 1, 0, 1, 0, ERR, 0));
      for (int i = 0; i < 16; i++)
         vecs.push_back(mk(0, 1, 0, 15 - i, i == 15, 0, (15 - i) <= 2, (15 - i) >= 12, i, ERR, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0, 32'hF, ERR, ERR));

      foreach (vecs[k]) begin
         step(vecs[k].wr, vecs[k].rd, vecs[k].din);
         chk($sformatf("v%0d_count", k), count, vecs[k].cnt);
         chk($sformatf("v%0d_empty", k), empty, vecs[k].emp);
         chk($sformatf("v%0d_full", k), full, vecs[k].ful);
         chk($sformatf("v%0d_aempty", k), almost_empty, vecs[k].ae);
         chk($sformatf("v%0d_afull", k), almost_full, vecs[k].af);
         chk($sformatf("v%0d_dout", k), data_out, vecs[k].dout);
         chk($sformatf("v%0d_ovf", k), overflow, vecs[k].ovf);
         chk($sformatf("v%0d_unf", k), underflow, vecs[k].unf);
      end

      // Simultaneous read/write in the middle of the range keeps the count constant.
      do_reset();
      for (int i = 0; i < 5; i++) push(32'h100 + i);
      for (int i = 0; i < 8; i++) begin
         logic [DW-1:0] e;
         step(1'b1, 1'b1, 32'h200 + i);
         e = exp_q.pop_front();
         exp_q.push_back(32'h200 + i);
         chk($sformatf("rw%0d_dout", i), data_out, e);
         chk($sformatf("rw%0d_count", i), count, 5);
      end
      for (int i = 0; i < 5; i++) pop_chk($sformatf("rw_drain%0d", i));
      chk("rw_end_empty", empty, 1);

      // At full, a combined request only reads; the write must not appear later.
      do_reset();
      for (int i = 0; i < 16; i++) push(32'h300 + i);
      step(1'b1, 1'b1, 32'hBEEF);
      chk("full_rw_dout", data_out, exp_q.pop_front());
      chk("full_rw_count", count, 15);
      chk("full_rw_full", full, 0);
      for (int i = 0; i < 15; i++) pop_chk($sformatf("full_rw_drain%0d", i));
      chk("full_rw_end_empty", empty, 1);
      chk("full_rw_end_count", count, 0);

      // Pointers wrap across three rounds of ten.
      do_reset();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 10; i++) push(32'h1000 * (r + 1) + i);
         chk($sformatf("wrap%0d_count", r), count, 10);
         for (int i = 0; i < 10; i++) pop_chk($sformatf("wrap%0d_rd%0d", r, i));
      end
      chk("wrap_end_count", count, 0);
      chk("wrap_end_empty", empty, 1);

      // Reset mid-operation with requests on the same edge.
      do_reset();
      for (int i = 0; i < 7; i++) push(32'h500 + i);
      step(1'b0, 1'b1, '0);
      reset   = 1'b1;
      step(1'b1, 1'b1, 32'h777);
      reset = 1'b0;
      exp_q.delete();
      chk("mid_reset_count", count, 0);
      chk("mid_reset_empty", empty, 1);
      chk("mid_reset_aempty", almost_empty, 1);
      chk("mid_reset_full", full, 0);
      chk("mid_reset_dout", data_out, 0);
      chk("mid_reset_ovf", overflow, 0);
      chk("mid_reset_unf", underflow, 0);
      push(32'hABC);
      chk("post_reset_count", count, 1);
      pop_chk("post_reset_rd");
      chk("post_reset_empty", empty, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // Overall time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
